// File: rtl/quant_pkg.sv
// Shared types and defaults for the pixel quantization stream controller.
package quant_pkg;

    localparam int unsigned PIX_IN_W  = 16;
    localparam int unsigned PIX_OUT_W = 8;
    localparam int unsigned CNT_W     = 16;

    localparam logic QMODE_8B = 1'b0;
    localparam logic QMODE_4B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/quant_round_sat.sv
// Combinational round-half-up quantizer with saturation to 8-bit or 4-bit range.
module quant_round_sat #(
    parameter int unsigned PIX_IN_W  = quant_pkg::PIX_IN_W,
    parameter int unsigned PIX_OUT_W = quant_pkg::PIX_OUT_W
) (
    input  logic [PIX_IN_W-1:0]  pixel,
    input  logic                 mode,
    output logic [PIX_OUT_W-1:0] q
);
    import quant_pkg::*;

    localparam int unsigned SH8 = PIX_IN_W - PIX_OUT_W;
    localparam int unsigned SH4 = PIX_IN_W - 4;
    localparam logic [PIX_IN_W:0] MAX8 = (PIX_IN_W+1)'((1 << PIX_OUT_W) - 1);
    localparam logic [PIX_IN_W:0] MAX4 = (PIX_IN_W+1)'(15);

    logic [PIX_IN_W:0] sum8;
    logic [PIX_IN_W:0] sum4;

    // One extra bit so the round-up carry out of the top is visible to saturation.
    assign sum8 = ({1'b0, pixel} >> SH8) + {{PIX_IN_W{1'b0}}, pixel[SH8-1]};
    assign sum4 = ({1'b0, pixel} >> SH4) + {{PIX_IN_W{1'b0}}, pixel[SH4-1]};

    always_comb begin
        q = '0;
        if (mode == QMODE_8B) begin
            if (sum8 > MAX8) q = '1;
            else             q = sum8[PIX_OUT_W-1:0];
        end else begin
            if (sum4 > MAX4) q = {{(PIX_OUT_W-4){1'b0}}, 4'hF};
            else             q = {{(PIX_OUT_W-4){1'b0}}, sum4[3:0]};
        end
    end

endmodule

// File: rtl/quant_stream_ctrl.sv
// Job controller: accepts num_pixels input pixels per start, quantizes them into a
// registered output stage, and raises a sticky done flag once all results drain.
module quant_stream_ctrl #(
    parameter int unsigned PIX_IN_W  = quant_pkg::PIX_IN_W,
    parameter int unsigned PIX_OUT_W = quant_pkg::PIX_OUT_W,
    parameter int unsigned CNT_W     = quant_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_clear_irq,
    input  logic [CNT_W-1:0]     i_num_pixels,
    input  logic                 i_quant_mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [PIX_IN_W-1:0]  s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PIX_OUT_W-1:0] m_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_W-1:0]     o_out_count
);
    import quant_pkg::*;

    state_t                state;
    logic [CNT_W-1:0]      num_pixels;
    logic [CNT_W-1:0]      in_count;
    logic [CNT_W-1:0]      out_count;
    logic                  quant_mode;
    logic                  valid_r;
    logic [PIX_OUT_W-1:0]  data_r;
    logic [PIX_OUT_W-1:0]  q;
    logic                  in_hs;
    logic                  out_hs;

    quant_round_sat #(
        .PIX_IN_W  (PIX_IN_W),
        .PIX_OUT_W (PIX_OUT_W)
    ) u_quant (
        .pixel (s_data),
        .mode  (quant_mode),
        .q     (q)
    );

    // The output stage may refill in the same cycle it is being emptied.
    assign s_ready = (state == ST_RUN) && (in_count != num_pixels) && (!valid_r || m_ready);
    assign in_hs   = s_valid && s_ready;
    assign out_hs  = valid_r && m_ready;

    assign m_valid     = valid_r;
    assign m_data      = data_r;
    assign o_busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign o_done      = (state == ST_DONE);
    assign o_out_count = out_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            num_pixels <= '0;
            in_count   <= '0;
            out_count  <= '0;
            quant_mode <= QMODE_8B;
            valid_r    <= 1'b0;
            data_r     <= '0;
        end else begin
            if (out_hs) out_count <= out_count + CNT_W'(1);

            if (in_hs) begin
                data_r   <= q;
                valid_r  <= 1'b1;
                in_count <= in_count + CNT_W'(1);
            end else if (out_hs) begin
                valid_r  <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        num_pixels <= i_num_pixels;
                        quant_mode <= i_quant_mode;
                        in_count   <= '0;
                        out_count  <= '0;
                        state      <= (i_num_pixels == '0) ? ST_DONE : ST_RUN;
                    end else if (state == ST_DONE && i_clear_irq) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (in_hs && (in_count + CNT_W'(1)) == num_pixels) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Only the final result can still be in the output register here.
                    if (out_hs) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quant_stream_ctrl.sv
// Randomized self-checking bench for quant_stream_ctrl against a queue-based job model.
module tb_quant_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_clear_irq = 1'b0;
    logic [15:0] i_num_pixels = '0;
    logic        i_quant_mode = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_out_count;

    quant_stream_ctrl #(
        .PIX_IN_W  (16),
        .PIX_OUT_W (8),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_clear_irq  (i_clear_irq),
        .i_num_pixels (i_num_pixels),
        .i_quant_mode (i_quant_mode),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_out_count  (o_out_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit mdl_busy, mdl_done, mdl_mode;
    int mdl_num, mdl_in, mdl_out;
    int pend[$];
    int src[$];
    int got[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int quant(int pix, bit mode);
        int q;
        if (!mode) begin
            q = (pix + 128) / 256;
            if (q > 255) q = 255;
        end else begin
            q = (pix + 2048) / 4096;
            if (q > 15) q = 15;
        end
        return q;
    endfunction

    task automatic model_reset();
        mdl_busy = 0; mdl_done = 0; mdl_mode = 0;
        mdl_num = 0; mdl_in = 0; mdl_out = 0;
        pend.delete();
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance one edge.
    task automatic step(input bit sv, input int d, input bit mr, input bit st, input bit clr,
                        input int n, input bit md, output bit in_hs);
        bit exp_sready, was_busy, was_done;
        s_valid = sv; s_data = d[15:0]; m_ready = mr;
        i_start = st; i_clear_irq = clr; i_num_pixels = n[15:0]; i_quant_mode = md;
        #2;
        exp_sready = mdl_busy && (mdl_in < mdl_num) && (pend.size() == 0 || mr);
        check("s_ready", s_ready, exp_sready);
        check("m_valid", m_valid, pend.size() > 0);
        if (pend.size() > 0) check("m_data", m_data, pend[0]);
        check("o_busy", o_busy, mdl_busy);
        check("o_done", o_done, mdl_done);
        check("o_out_count", o_out_count, mdl_out);
        in_hs = sv && exp_sready;
        was_busy = mdl_busy;
        was_done = mdl_done;
        if (pend.size() > 0 && mr) begin
            got.push_back(int'(m_data));
            void'(pend.pop_front());
            mdl_out++;
        end
        if (in_hs) begin
            pend.push_back(quant(d, mdl_mode));
            mdl_in++;
        end
        if (mdl_busy && mdl_in == mdl_num && pend.size() == 0) begin
            mdl_busy = 0;
            mdl_done = 1;
        end
        if (st && !was_busy) begin
            mdl_num = n; mdl_mode = md; mdl_in = 0; mdl_out = 0;
            if (n == 0) begin
                mdl_done = 1;
            end else begin
                mdl_busy = 1;
                mdl_done = 0;
            end
        end else if (clr && was_done) begin
            mdl_done = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int n, input bit md, input bit rnd, input bit clr_with_start,
                           input bit inject_start);
        int cyc, d, nn;
        bit hs, sv, mr, st, clr;
        got.delete();
        step(0, 0, 1, 1, clr_with_start, n, md, hs);
        cyc = 0;
        while (mdl_busy && cyc < 4000) begin
            sv  = (src.size() > 0) && (!rnd || ($urandom_range(0, 1) == 1));
            mr  = !rnd || ($urandom_range(0, 2) != 0);
            d   = sv ? src[0] : int'($urandom_range(0, 65535));
            st  = inject_start && (cyc == 3);
            clr = rnd && ($urandom_range(0, 7) == 0);
            nn  = st ? 5 : int'($urandom_range(0, 65535));
            step(sv, d, mr, st, clr, nn, ~md, hs);
            if (hs) void'(src.pop_front());
            cyc++;
        end
        check("job_in_budget", cyc < 4000, 1);
    endtask

    initial begin
        bit hs;
        int exp0[4];
        int exp1[3];
        exp0 = '{32'h00, 32'h01, 32'h02, 32'hFF};
        exp1 = '{32'h01, 32'h02, 32'h0F};
        model_reset();
        #2;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_count", o_out_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 1, 0, 0, 0, 0, hs);

        // Mode 0 back-to-back.
        src = '{32'h0000, 32'h017F, 32'h0180, 32'hFFFF};
        run_job(4, 0, 0, 0, 0);
        check("m8_num_out", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("m8_data", got[i], exp0[i]);
        check("m8_count", o_out_count, 4);
        check("m8_done", o_done, 1);
        step(0, 0, 1, 0, 0, 0, 0, hs);

        // Clear in DONE, then mode 1.
        step(0, 0, 1, 0, 1, 0, 0, hs);
        check("clear_done", o_done, 0);
        step(0, 0, 1, 0, 0, 0, 0, hs);
        src = '{32'h17FF, 32'h1800, 32'hF800};
        run_job(3, 1, 0, 0, 0);
        check("m4_num_out", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("m4_data", got[i], exp1[i]);

        // Start plus clear in DONE, random flow, start injected while running.
        src.delete();
        for (int i = 0; i < 32; i++) src.push_back(int'($urandom_range(0, 65535)));
        run_job(32, 0, 1, 1, 1);
        check("bp_num_out", got.size(), 32);
        check("bp_count", o_out_count, 32);
        step(0, 0, 1, 0, 0, 0, 0, hs);

        // Random mode 1 job with backpressure.
        src.delete();
        for (int i = 0; i < 20; i++) src.push_back(int'($urandom_range(0, 65535)));
        run_job(20, 1, 1, 0, 0);
        check("bp4_count", o_out_count, 20);

        // Zero length job.
        run_job(0, 0, 0, 0, 0);
        check("zero_done", o_done, 1);
        check("zero_busy", o_busy, 0);
        step(0, 0, 1, 0, 1, 0, 0, hs);
        step(0, 0, 1, 0, 0, 0, 0, hs);

        // Reset after 3 of 8 pixels.
        src.delete();
        for (int i = 0; i < 8; i++) src.push_back(int'($urandom_range(0, 65535)));
        step(0, 0, 1, 1, 0, 8, 0, hs);
        for (int c = 0; c < 20 && mdl_in < 3; c++) begin
            step(1, src[0], 1, 0, 0, 0, 0, hs);
            if (hs) void'(src.pop_front());
        end
        check("pre_rst_in", mdl_in, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_ready", s_ready, 0);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_count", o_out_count, 0);
        model_reset();
        src.delete();
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 1, 0, 0, 0, 0, hs);
        src = '{int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535))};
        run_job(2, 0, 0, 0, 0);
        check("post_rst_count", o_out_count, 2);
        check("post_rst_done", o_done, 1);
        step(0, 0, 1, 0, 0, 0, 0, hs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
